// File: rtl/aes_pkg.sv
// Shared Rijndael constants and helpers for the ShiftRows datapath.
package aes_pkg;

  localparam int unsigned NB_128 = 4;
  localparam int unsigned NB_192 = 6;
  localparam int unsigned NB_256 = 8;

  typedef enum logic {
    AES_ENC = 1'b0,
    AES_DEC = 1'b1
  } aes_mode_e;

  function automatic bit nb_legal(input int unsigned nb);
    return (nb == NB_128) || (nb == NB_192) || (nb == NB_256);
  endfunction

  // Rows 2 and 3 shift one further for the 256-bit block.
  function automatic int unsigned shift_of(input int unsigned nb, input int unsigned r);
    if ((nb == NB_256) && (r >= 2)) begin
      return r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int unsigned NB = 4,
  localparam int unsigned W = 32 * NB
) (
  input  logic [W-1:0] data_i,
  input  logic         dec_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] enc_d;
  logic [W-1:0] dec_d;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned S      = shift_of(NB, r);
      localparam int unsigned EncSrc = (c + S) % NB;
      localparam int unsigned DecSrc = (c + NB - S) % NB;
      assign enc_d[8*idx(r, c) +: 8] = data_i[8*idx(r, EncSrc) +: 8];
      assign dec_d[8*idx(r, c) +: 8] = data_i[8*idx(r, DecSrc) +: 8];
    end
  end

  always_comb begin
    data_o = (aes_mode_e'(dec_i) == AES_DEC) ? dec_d : enc_d;
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows engine: main output register plus one skid register.
// Optional SHIFT_ROWS_PIPE_BYPASS_EN adds in_bypass to pass words unpermuted.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NB = 4,
  localparam int unsigned W = 32 * NB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_dec,
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  input  logic         in_bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  if (!nb_legal(NB)) begin : g_nb_illegal
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0] perm;
  logic [W-1:0] word_in;
  logic         accept;
  logic         drain;

  logic         main_valid_q, main_valid_d;
  logic [W-1:0] main_q, main_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_q, skid_d;

  shift_rows_perm #(
    .NB(NB)
  ) u_perm (
    .data_i(in_data),
    .dec_i (in_dec),
    .data_o(perm)
  );

  always_comb begin
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    word_in = in_bypass ? in_data : perm;
`else
    word_in = perm;
`endif
  end

  always_comb begin
    accept       = in_valid & ~skid_valid_q;
    drain        = main_valid_q & out_ready;
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (!main_valid_q || drain) begin
      // Skid is older than anything arriving now; accept is blocked while it is full.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_d = word_in;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = word_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

endmodule
